button_conditioner: RTL and testbench



---
 rtl/button_conditioner_if.sv | 25 ++
 rtl/button_conditioner.sv | 136 +++++++++++++
 tb/tb_button_conditioner.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - button pins in, debounced level and press/release pulses out
interface button_conditioner_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  // board side: drives the raw pins, consumes the conditioned outputs
  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  // conditioner side
  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-button synchroniser, debouncer and edge pulser; optional auto-repeat under `BTN_AUTO_REPEAT_EN
module button_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic                 clk,
  input  logic                 resetn,
  button_conditioner_if.slave  btn
);

  localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations where a counter would have nothing to count.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
    $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int               RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int               RPT_W   = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic {
    PH_DELAY  = 1'b0,
    PH_PERIOD = 1'b1
  } rpt_phase_e;
`endif

  wire [NUM_BTN-1:0] level_w;
  wire [NUM_BTN-1:0] press_w;
  wire [NUM_BTN-1:0] release_w;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            rise, fall;

    // two-flop synchroniser; only sync2_q is seen by the rest of the channel
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= btn.btn_in[g];
        sync2_q <= sync1_q;
      end
    end

    // debounce: a new value must persist unbroken for DEBOUNCE_CYCLES before it is taken
    always_comb begin
      level_d  = level_q;
      db_cnt_d = db_cnt_q;
      if (sync2_q == level_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q != DB_LAST) begin
        db_cnt_d = db_cnt_q + 1'b1;
      end else begin
        level_d  = sync2_q;
        db_cnt_d = '0;
      end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

`ifdef BTN_AUTO_REPEAT_EN
    rpt_phase_e       phase_q, phase_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_fire;

    // repeat timer: runs only while the accepted level is held high, restarts on press/release
    always_comb begin
      rpt_cnt_d = rpt_cnt_q;
      phase_d   = phase_q;
      rpt_fire  = 1'b0;
      if (!level_q || !level_d) begin
        rpt_cnt_d = '0;
        phase_d   = PH_DELAY;
      end else if (rpt_cnt_q == ((phase_q == PH_DELAY) ? RD_LAST : RP_LAST)) begin
        rpt_fire  = 1'b1;
        rpt_cnt_d = '0;
        phase_d   = PH_PERIOD;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end

    // repeat timer state register
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        rpt_cnt_q <= '0;
        phase_q   <= PH_DELAY;
      end else begin
        rpt_cnt_q <= rpt_cnt_d;
        phase_q   <= phase_d;
      end
    end

    assign press_d = rise | rpt_fire;
`else
    assign press_d = rise;
`endif
    assign release_d = fall;

    // accepted level, debounce count and the one-cycle pulses all update on the same edge
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        level_q   <= 1'b0;
        db_cnt_q  <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        level_q   <= level_d;
        db_cnt_q  <= db_cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign level_w[g]   = level_q;
    assign press_w[g]   = press_q;
    assign release_w[g] = release_q;
  end

  assign btn.btn_level   = level_w;
  assign btn.btn_press   = press_w;
  assign btn.btn_release = release_w;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
module tb_button_conditioner;

  localparam int NB   = 4;
  localparam int LAT  = 6;   // drive at a negedge -> visible after the 6th following edge
  localparam int RD   = 10;
  localparam int RP   = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    int             cyc;
    logic [NB-1:0]  press;
    logic [NB-1:0]  rel;
  } ev_t;

  ev_t           sb[$];
  logic [NB-1:0] exp_level = '0;

  button_conditioner_if #(.NUM_BTN(NB)) bus ();

  button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .btn   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // expected events for inputs in mask m rising at cycle t0 and falling at t1
  task automatic push_hold(input logic [NB-1:0] m, input int t0, input int t1);
    sb.push_back('{cyc: t0 + LAT, press: m, rel: '0});
`ifdef BTN_AUTO_REPEAT_EN
    for (int r = t0 + LAT + RD; r < t1 + LAT; r += RP)
      sb.push_back('{cyc: r, press: m, rel: '0});
`endif
    sb.push_back('{cyc: t1 + LAT, press: '0, rel: m});
  endtask

  task automatic run_hold(input logic [NB-1:0] m, input int hold);
    int t0;
    t0 = cyc;
    bus.btn_in = bus.btn_in | m;
    push_hold(m, t0, t0 + hold);
    step(hold);
    bus.btn_in = bus.btn_in & ~m;
    step(12);
  endtask

  // monitor: every cycle, outputs must match whatever the scoreboard holds for this cycle
  always begin
    logic [NB-1:0] ep, er;
    @(negedge clk);
    #1;
    ep = '0;
    er = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        ep = ep | sb[i].press;
        er = er | sb[i].rel;
        sb.delete(i);
      end
    end
    exp_level = (exp_level | ep) & ~er;
    check("press",   32'(bus.btn_press),   32'(ep));
    check("release", 32'(bus.btn_release), 32'(er));
    check("level",   32'(bus.btn_level),   32'(exp_level));
  end

  initial begin
    int t0;
    bus.btn_in = '0;
    step(3);
    resetn = 1'b1;
    step(3);

    // clean press on bit 0
    run_hold(4'b0001, 20);

    // bounce on bit 1, then a solid press
    for (int k = 0; k < 2; k++) begin
      bus.btn_in[1] = 1'b1;
      step(2);
      bus.btn_in[1] = 1'b0;
      step(2);
    end
    run_hold(4'b0010, 20);

    // bits 2 and 3 together
    run_hold(4'b1100, 15);

    // long hold on bit 0 exercises auto-repeat when enabled
    run_hold(4'b0001, 46);

    // reset in the middle of a debounce with the input still high
    bus.btn_in[0] = 1'b1;
    step(4);
    resetn = 1'b0;
    sb.delete();
    exp_level = '0;
    step(3);
    resetn = 1'b1;
    t0 = cyc;
    push_hold(4'b0001, t0, t0 + 20);
    step(20);
    bus.btn_in[0] = 1'b0;
    step(12);

    // press on bit 3 overlapping a release on bit 2
    bus.btn_in[2] = 1'b1;
    t0 = cyc;
    push_hold(4'b0100, t0, t0 + 12);
    step(12);
    bus.btn_in[2] = 1'b0;
    run_hold(4'b1000, 14);

    step(4);
    check("pending", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
